// File: rtl/ex_mdu.sv
// Multiply/divide unit for the E stage: a multi-cycle HI/LO producer with mthi/mtlo/mfhi/mflo.
// The result is computed on the start edge and held as pending until the busy window ends.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StartE,
  output logic        BusyE,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOutE
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW_RQ = $clog2(MAXC + 1);
  localparam int CW    = (CW_RQ < 4) ? 4 : CW_RQ;

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic [31:0]   res_hi, res_lo;
  logic          is_mul, is_div, div_zero;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] dsor, quot_u, rem_u;
  logic signed [31:0] quot_s, rem_s;

  assign is_mul   = (MDUOpE == OP_MULT) || (MDUOpE == OP_MULTU);
  assign is_div   = (MDUOpE == OP_DIV)  || (MDUOpE == OP_DIVU);
  assign div_zero = (SrcBE == 32'd0);
  assign StartE   = (is_mul || is_div) && !Req;

  assign a_sx   = {{32{SrcAE[31]}}, SrcAE};
  assign b_sx   = {{32{SrcBE[31]}}, SrcBE};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, SrcAE} * {32'd0, SrcBE};

  // Divisor forced to 1 on divide-by-zero so the datapath never sees x/0; result is discarded anyway.
  assign dsor   = div_zero ? 32'd1 : SrcBE;
  assign quot_s = $signed(SrcAE) / $signed(dsor);
  assign rem_s  = $signed(SrcAE) % $signed(dsor);
  assign quot_u = SrcAE / dsor;
  assign rem_u  = SrcAE % dsor;

  always_comb begin
    res_hi = HI;
    res_lo = LO;
    case (MDUOpE)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   if (!div_zero) begin res_hi = rem_s; res_lo = quot_s; end
      OP_DIVU:  if (!div_zero) begin res_hi = rem_u; res_lo = quot_u; end
      default:  ;
    endcase
  end

  always_comb begin
    MDUOutE = 32'd0;
    if (MDUOpE == OP_MFHI)      MDUOutE = HI;
    else if (MDUOpE == OP_MFLO) MDUOutE = LO;
  end

  // Divide-by-zero captures the current HI/LO as pending, so completion rewrites the same values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI      <= 32'd0;
      LO      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      cnt     <= '0;
      BusyE   <= 1'b0;
    end else if (!BusyE) begin
      if (StartE) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        BusyE   <= 1'b1;
      end else if (!Req && MDUOpE == OP_MTHI) begin
        HI <= SrcAE;
      end else if (!Req && MDUOpE == OP_MTLO) begin
        LO <= SrcAE;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        HI    <= pend_hi;
        LO    <= pend_lo;
        BusyE <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Req  input  1  exception/interrupt flush request for the E-stage instruction.
REQ-006 SHALL have port MDUOpE  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-007 SHALL have port SrcAE  input  32  operand rs, already forwarded.
REQ-008 SHALL have port SrcBE  input  32  operand rt, already forwarded.
REQ-009 SHALL have port StartE  output  1  combinational, high when MDUOpE is 1-4 and Req=0.
REQ-010 SHALL have port BusyE  output  1  registered, high while an operation is in flight.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.
REQ-013 SHALL have port MDUOutE  output  32  combinational: HI when MDUOpE=5, LO when MDUOpE=6, else 0; feeds ResultE into the E/M register.

Function
REQ-014 SHALL hold state: HI, LO, pending HI/LO result registers, down-counter cnt (4 bits min), BusyE.
REQ-015 SHALL, on a rising edge with StartE=1 and BusyE=0, compute and capture the full 64-bit result into the pending registers, load cnt with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4), and set BusyE=1.
REQ-016 SHALL implement mult as signed 32x32->64 (HI=upper, LO=lower) and multu as the unsigned equivalent.
REQ-017 SHALL implement div as signed quotient to LO, remainder to HI, truncating toward zero with remainder sign matching the dividend; divu as the unsigned equivalent.
REQ-018 SHALL, for div/divu with SrcBE=0, still assert BusyE for DIV_CYCLES but leave HI and LO unchanged at completion.
REQ-019 SHALL decrement cnt each cycle while BusyE=1; on the edge where cnt goes 1->0, SHALL write pending values to HI/LO and clear BusyE in the same edge.
REQ-020 SHALL therefore keep BusyE high for exactly N consecutive cycles after the start edge (N=MULT_CYCLES or DIV_CYCLES), with new HI/LO visible in the first cycle BusyE=0.
REQ-021 SHALL ignore any MDUOpE 1-8 arriving while BusyE=1; the hazard unit stalls on StartE|BusyE with an MDU op in E, so this case indicates a stall bug and SHALL NOT corrupt state.
REQ-022 SHALL, on a rising edge with MDUOpE=7 (mthi), BusyE=0 and Req=0, write SrcAE to HI; with MDUOpE=8 (mtlo), write SrcAE to LO.
REQ-023 SHALL, when Req=1, suppress StartE, mthi and mtlo for that edge (instruction is being flushed); an operation already in flight SHALL run to completion and update HI/LO.
REQ-024 SHALL make MDUOutE reflect the current HI/LO registers with no bypass of in-flight or same-cycle mthi/mtlo values.
REQ-025 SHALL have no effect on HI/LO for MDUOpE in {0, 5, 6, 9-15}.

Reset
REQ-026 SHALL, while reset=0, asynchronously force HI=0, LO=0, pending registers=0, cnt=0 and BusyE=0, independent of clk.
REQ-027 SHALL abort any in-flight operation on reset assertion without updating HI/LO afterwards; StartE and MDUOutE follow their combinational definitions during reset.
REQ-028 SHALL resume normal operation on the first rising edge after reset returns high.

Verification
REQ-029 SHALL pass: mult with SrcAE=0xFFFFFFFE, SrcBE=3 -> BusyE high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL pass: div with SrcAE=0xFFFFFFF9 (-7), SrcBE=2 -> BusyE high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 with HI=0x11, LO=0x22 -> after 10 busy cycles, HI=0x11, LO=0x22.
REQ-031 SHALL pass: mthi 0xDEADBEEF, then mflo/mfhi -> MDUOutE=0xDEADBEEF for mfhi on the next cycle, BusyE stays 0.
REQ-032 SHALL pass: mult issued with Req=1 -> StartE=0, BusyE stays 0, HI/LO unchanged; mtlo with Req=1 -> LO unchanged.
REQ-033 SHALL pass: Req=1 asserted on the 2nd busy cycle of a div -> div completes on schedule and HI/LO update.
REQ-034 SHALL pass: reset pulled low on the 3rd busy cycle of a mult -> BusyE=0, HI=LO=0 immediately; no later HI/LO update.
